// File: rtl/conv_pkg.sv
// Shared definitions for the 4x4-data / 3x3-filter convolution path.
// Holds the scheduler state encoding, geometry constants and the default
// operand/accumulator widths.
// Optional build macro: CONV_SIGNED_EN (two's-complement datapath).
package conv_pkg;

  localparam int IMG  = 4;   // data tile is IMG x IMG
  localparam int K    = 3;   // filter is K x K
  localparam int OUT  = 2;   // output tile is OUT x OUT
  localparam int TAPS = 9;   // K*K products per output element

  localparam int DW_DEF    = 8;
  localparam int ACC_W_DEF = 2 * DW_DEF + 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_MAC  = 3'd3,
    ST_EMIT = 3'd4,
    ST_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/conv_mac_unit.sv
// Single multiply-accumulate unit for the convolution path.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : synchronous accumulator clear (wins over i_en)
//   i_en           : accumulate i_a*i_b this cycle
//   i_a, i_b       : DW-bit operands
//   o_sum          : accumulator plus the current product (combinational),
//                    used to capture the final tap without an extra cycle
// Build macro CONV_SIGNED_EN selects a signed multiplier/accumulator.
module conv_mac_unit #(
  parameter int DW    = 8,
  parameter int ACC_W = 2 * DW + 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DW-1:0]    i_a,
  input  logic [DW-1:0]    i_b,
  output logic [ACC_W-1:0] o_sum
);

  logic [ACC_W-1:0] r_acc;

`ifdef CONV_SIGNED_EN
  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACC_W-1:0] w_sum;
  assign w_prod = $signed(i_a) * $signed(i_b);
  // the size cast keeps the product signed, so it sign-extends
  assign w_sum  = $signed(r_acc) + ACC_W'(w_prod);
`else
  logic [2*DW-1:0]  w_prod;
  logic [ACC_W-1:0] w_sum;
  assign w_prod = i_a * i_b;
  assign w_sum  = r_acc + ACC_W'(w_prod);
`endif

  assign o_sum = w_sum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= w_sum;
  end

endmodule

// File: rtl/conv_window_scheduler.sv
// Sequencing controller for the 4x4 / 3x3 valid convolution (2x2 outputs).
// Start -> pulse o_load_en -> wait i_load_done -> for each of 4 windows run
// 9 MAC cycles, then present the result on a valid/ready port -> o_done.
// Ports:
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_start               : job request, honoured only in IDLE
//   o_busy                : high outside IDLE
//   o_load_en/i_load_done : operand memory activate strobe / done pulse
//   i_a_flat, i_b_flat    : 4x4 data, 3x3 filter (row-major, DW per element)
//   o_out_data/o_out_pos  : result and window index {row,col}
//   o_out_valid/i_out_ready : result handshake
//   o_done                : one-cycle end-of-job pulse
// Build macro CONV_SIGNED_EN makes operands and result two's-complement.
module conv_window_scheduler
  import conv_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int ACC_W = 2 * DW + 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_load_en,
  input  logic               i_load_done,
  input  logic [16*DW-1:0]   i_a_flat,
  input  logic [9*DW-1:0]    i_b_flat,
  output logic [ACC_W-1:0]   o_out_data,
  output logic [1:0]         o_out_pos,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic               o_done
);

  state_e           r_state;
  logic [1:0]       r_p;
  logic [3:0]       r_tap;
  logic [ACC_W-1:0] r_out_data;

  logic [1:0]       w_i, w_j;
  logic [1:0]       w_row, w_col;
  logic [3:0]       w_aidx, w_bidx;
  logic [DW-1:0]    w_a, w_b;
  logic [ACC_W-1:0] w_sum;
  logic             w_last_tap;

  // tap -> (i, j) = (tap/3, tap%3) without a divider
  always_comb begin
    w_i = 2'd0;
    w_j = 2'(r_tap);
    if (r_tap >= 4'd6) begin
      w_i = 2'd2;
      w_j = 2'(r_tap - 4'd6);
    end else if (r_tap >= 4'd3) begin
      w_i = 2'd1;
      w_j = 2'(r_tap - 4'd3);
    end
  end

  // window origin is (p[1], p[0]); IMG=4 makes the data index just {row,col}
  assign w_row  = {1'b0, r_p[1]} + w_i;
  assign w_col  = {1'b0, r_p[0]} + w_j;
  assign w_aidx = {w_row, w_col};
  assign w_bidx = 4'(w_i) * 4'(K) + 4'(w_j);
  assign w_a    = i_a_flat[w_aidx*DW +: DW];
  assign w_b    = i_b_flat[w_bidx*DW +: DW];

  assign w_last_tap = (r_tap == 4'(TAPS - 1));

  // accumulator is held at zero outside MAC, so every window starts clean
  conv_mac_unit #(.DW(DW), .ACC_W(ACC_W)) u_mac (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (r_state != ST_MAC),
    .i_en    (r_state == ST_MAC),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_sum   (w_sum)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_p        <= '0;
      r_tap      <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) r_state <= ST_LOAD;
        ST_LOAD: r_state <= ST_WAIT;
        ST_WAIT: if (i_load_done) begin
          r_state <= ST_MAC;
          r_tap   <= '0;
        end
        ST_MAC: begin
          if (w_last_tap) begin
            r_out_data <= w_sum;   // final tap folded in directly
            r_tap      <= '0;
            r_state    <= ST_EMIT;
          end else begin
            r_tap <= r_tap + 4'd1;
          end
        end
        ST_EMIT: if (i_out_ready) begin
          if (r_p == 2'd3) begin
            r_state <= ST_DONE;
          end else begin
            r_p     <= r_p + 2'd1;
            r_tap   <= '0;
            r_state <= ST_MAC;
          end
        end
        ST_DONE: begin
          r_p     <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_load_en   = (r_state == ST_LOAD);
  assign o_out_valid = (r_state == ST_EMIT);
  assign o_done      = (r_state == ST_DONE);
  assign o_out_data  = r_out_data;
  assign o_out_pos   = r_p;

endmodule

// File: doc/conv_window_scheduler.md
# conv_window_scheduler

Sequencing controller for the 4x4-data / 3x3-filter convolution path. On `start` it pulses the operand memory's load strobe and waits for its done pulse. It then walks the four valid 3x3 window positions and accumulates one tap per cycle in a single multiply-accumulate unit. Each 2x2 output element is presented on a valid/ready port, and `done` is pulsed once the job completes.

## Interface
- `DW`, default 8: operand width, for both data and filter elements.
- `ACC_W`, default `2*DW+4` (20): accumulator and result width. This is sufficient for 9 full-scale products.
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `start`  in  1  job request. Sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `load_en`  out  1  one-cycle strobe to the operand memory's activate input.
- `load_done`  in  1  operand memory's activate-done pulse.
- `a_flat`  in  16*DW  4x4 data. Element (r,c) is at `[(4r+c)*DW +: DW]`.
- `b_flat`  in  9*DW  3x3 filter. Element (i,j) is at `[(3i+j)*DW +: DW]`.
- `out_data`  out  ACC_W  convolution result for the current position.
- `out_pos`  out  2  output position index p. Row is p[1], column is p[0].
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `done`  out  1  one-cycle pulse at the end of a job.

## Operation
- States and transitions:
  - IDLE: if `start`=1, go to LOAD.
  - LOAD: `load_en`=1; go to WAIT.
  - WAIT: if `load_done`=1, go to MAC with tap=0 and acc=0.
  - MAC: acc += a(p[1]+i, p[0]+j) * b(i,j), where i=tap/3 and j=tap%3.
    - After tap 8: register the final sum into `out_data` and go to EMIT.
  - EMIT: `out_valid`=1. On `out_valid`&&`out_ready`:
    - if p=3, go to DONE;
    - otherwise increment p, clear tap and acc, and go to MAC.
  - DONE: `done`=1; go to IDLE, with p cleared.
- Output order is p = 0,1,2,3, i.e. windows (0,0), (0,1), (1,0), (1,1).
- `start` outside IDLE is ignored, with no queuing.
- `load_done` outside WAIT is ignored.
- WAIT has no timeout.
- The datapath is unsigned by default (see Configuration).
- The full-width sum never overflows ACC_W, so no saturation or wrap logic is needed.
- `a_flat` and `b_flat` must remain stable from `load_done` until `done`. The memory guarantees this by not re-activating while `busy`=1.

## Timing
- Reset (async assert, sync release):
  - state goes to IDLE, and p, tap and acc are cleared;
  - `busy`, `load_en`, `out_valid` and `done` go to 0;
  - `out_data` and `out_pos` go to 0.
- Reset mid-job aborts immediately. No output is produced for the partial position.
- All outputs are registered or Moore-decoded from state. None are combinational from inputs.
- With `start` sampled at edge 0:
  - `load_en` is high in cycle 1.
  - The memory answers `load_done` in cycle 2.
  - MAC runs for cycles 3–11.
  - The first `out_valid` is in cycle 12.
- Each position costs 9 MAC cycles plus at least one EMIT cycle.
- With `out_ready` held at 1:
  - outputs appear in cycles 12, 22, 32 and 42;
  - `done` is in cycle 43;
  - `busy` is low again from cycle 44.
- Backpressure: while `out_ready`=0, EMIT holds, and `out_data`/`out_pos` stay stable.
- `out_valid` never drops without a handshake (except reset).

## Configuration
- `CONV_SIGNED_EN` defined:
  - `a_flat` and `b_flat` elements are two's-complement signed;
  - the products and accumulator are signed;
  - `out_data` is signed ACC_W.
- Without the macro, all operands and the result are unsigned.
- State timing and encoding are identical in both builds.

## Structure
- Shared package `conv_pkg` holds:
  - the state enum (IDLE, LOAD, WAIT, MAC, EMIT, DONE);
  - constants IMG=4, K=3, OUT=2, TAPS=9;
  - the default DW and ACC_W.
- Sub-module `conv_mac_unit`:
  - inputs: DW x DW multiplier, clear, enable;
  - ACC_W accumulator register;
  - signedness follows `CONV_SIGNED_EN`.
- The top level holds the FSM, the tap/position counters and the operand mux.

## Test plan
- All a=1, all b=1, `out_ready`=1 → outputs 9,9,9,9 at cycles 12/22/32/42 with `out_pos` 0..3, then `done` in cycle 43.
- a(r,c)=4r+c, all b=1 → outputs 45, 54, 81, 90 in order.
- a(r,c)=4r+c, only b(1,1)=1 → outputs 5, 6, 9, 10.
- All a=255, all b=255 → 585225 on every output, with no overflow.
- First EMIT with `out_ready`=0 for 5 cycles, plus `start` pulsed during MAC:
  - `out_data`=45 is held stable;
  - p does not advance;
  - the extra `start` is ignored;
  - the job completes with exactly 4 outputs.
- `rst_n` low during the second position's MAC cycles:
  - all outputs drop to 0 at once and the FSM is in IDLE;
  - a new `start` yields the correct full sequence.
- With `CONV_SIGNED_EN`, all a=0xFF (-1) and all b=1 → -9 on every output. Without the macro, the same stimulus → 2295.
